// File: rtl/osd_spi_tx.sv
// SPI mode-0 master for the OSD link: sends one command byte and, for line
// writes, streams 256 bitmap bytes prefetched from a synchronous RAM.
module osd_spi_tx #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [3:0] cmd_line,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(SS_GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, END} state_t;

    state_t     r_state;
    logic [7:0] r_div;
    logic       r_phase;
    logic [2:0] r_bitCnt;
    logic [8:0] r_byteCnt;
    logic       r_isWrite;
    logic [7:0] r_shift;
    logic [7:0] r_prefetch;
    logic       r_rdPend;
    logic [3:0] r_gapCnt;

    logic       w_tick;
    logic       w_start;
    logic [7:0] w_cmdByte;
    logic [8:0] w_lastByte;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_start    = cmd_valid && (r_state == IDLE) && (cmd_type != 2'd3);
    assign w_lastByte = r_isWrite ? 9'd256 : 9'd0;
    assign cmd_ready  = (r_state == IDLE) && reset_n;
    assign SPI_DI     = r_shift[7];

    always_comb begin
        w_cmdByte = {4'b0010, cmd_line};
        case (cmd_type)
            2'd0:    w_cmdByte = 8'h40;
            2'd1:    w_cmdByte = 8'h41;
            default: w_cmdByte = {4'b0010, cmd_line};
        endcase
    end

    // The shifter MSB drives DI directly, so DI only moves on the edges where
    // SCK falls (or at the start of SETUP) and is stable across each rise.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_div      <= 8'd0;
            r_phase    <= 1'b0;
            r_bitCnt   <= 3'd0;
            r_byteCnt  <= 9'd0;
            r_isWrite  <= 1'b0;
            r_shift    <= 8'd0;
            r_prefetch <= 8'd0;
            r_rdPend   <= 1'b0;
            r_gapCnt   <= 4'd0;
            rd_en      <= 1'b0;
            rd_addr    <= 8'd0;
            busy       <= 1'b0;
            SPI_SCK    <= 1'b0;
            SPI_SS3    <= 1'b1;
        end else begin
            rd_en    <= 1'b0;
            r_rdPend <= rd_en;
            if (r_rdPend) begin
                r_prefetch <= rd_data;
            end
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= SETUP;
                        r_div     <= 8'd0;
                        r_phase   <= 1'b0;
                        r_bitCnt  <= 3'd7;
                        r_byteCnt <= 9'd0;
                        r_isWrite <= (cmd_type == 2'd2);
                        r_shift   <= w_cmdByte;
                        busy      <= 1'b1;
                        SPI_SS3   <= 1'b0;
                        if (cmd_type == 2'd2) begin
                            rd_en   <= 1'b1;
                            rd_addr <= 8'd0;
                        end
                    end
                end

                SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            SPI_SCK <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            SPI_SCK <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bitCnt != 3'd0) begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitCnt <= r_bitCnt - 3'd1;
                            end else if (r_byteCnt == w_lastByte) begin
                                r_state  <= END;
                                r_shift  <= 8'd0;
                                r_gapCnt <= GAP_LAST;
                                SPI_SS3  <= 1'b1;
                            end else begin
                                // Byte boundary: load the prefetched byte and
                                // request the one after it, stopping at 255.
                                r_shift   <= r_prefetch;
                                r_bitCnt  <= 3'd7;
                                r_byteCnt <= r_byteCnt + 9'd1;
                                if (r_byteCnt < 9'd255) begin
                                    rd_en   <= 1'b1;
                                    rd_addr <= r_byteCnt[7:0] + 8'd1;
                                end
                            end
                        end
                    end
                end

                END: begin
                    if (w_tick) begin
                        if (r_gapCnt == 4'd0) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_gapCnt <= r_gapCnt - 4'd1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
